// File: rtl/load_store_unit_pkg.sv
// Shared types for the memory-access stage: opcode, access size and FSM state encodings.
package load_store_unit_pkg;

  typedef enum logic [3:0] {
    MEM_NONE,
    LB,
    LH,
    LW,
    LBU,
    LHU,
    SB,
    SH,
    SW
  } mem_op;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_B,
    SZ_H,
    SZ_W
  } op_size_t;

  function automatic logic op_is_store(input mem_op op);
    return op inside {SB, SH, SW};
  endfunction

  function automatic op_size_t op_size(input mem_op op);
    case (op)
      LB, LBU, SB: return SZ_B;
      LH, LHU, SH: return SZ_H;
      LW, SW:      return SZ_W;
      default:     return SZ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Load lane select and sign/zero extension; purely combinational, no backpressure.
module load_align
  import load_store_unit_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int OFFW      = $clog2(BUS_WIDTH / 8)
) (
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  input  logic [OFFW-1:0]      offset,
  input  mem_op                op,
  output logic [BUS_WIDTH-1:0] rdata
);

  logic [BUS_WIDTH-1:0] lane;

  assign lane = mem_rdata >> {offset, 3'b000};

  always_comb begin
    rdata = lane;
    case (op)
      LB:      rdata = {{(BUS_WIDTH-8){lane[7]}}, lane[7:0]};
      LBU:     rdata = {{(BUS_WIDTH-8){1'b0}}, lane[7:0]};
      LH:      rdata = {{(BUS_WIDTH-16){lane[15]}}, lane[15:0]};
      LHU:     rdata = {{(BUS_WIDTH-16){1'b0}}, lane[15:0]};
      default: rdata = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// One data-memory transaction per accepted start; done >= 2 cycles after start (1 if misaligned).
// Holds mem_req until mem_ack or TIMEOUT cycles; start is dropped, not queued, while busy.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  mem_op                  op,
  input  logic [BUS_WIDTH-1:0]   addr,
  input  logic [BUS_WIDTH-1:0]   wdata,
  output logic                   busy,
  output logic                   done,
  output logic [BUS_WIDTH-1:0]   rdata,
  output logic                   misaligned,
  output logic                   bus_err,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [BUS_WIDTH-1:0]   mem_addr,
  output logic [BUS_WIDTH/8-1:0] mem_be,
  output logic [BUS_WIDTH-1:0]   mem_wdata,
  input  logic [BUS_WIDTH-1:0]   mem_rdata,
  input  logic                   mem_ack
);

  localparam int NB   = BUS_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = $clog2(TIMEOUT);

  lsu_state_t           state;
  logic [CNTW-1:0]      cnt;
  mem_op                op_q;
  logic [OFFW-1:0]      off_q;

  logic [OFFW-1:0]      off_in;
  logic                 aligned_in;
  logic [NB-1:0]        be_in;
  logic [BUS_WIDTH-1:0] wdata_rep;
  logic [BUS_WIDTH-1:0] load_data;

  assign off_in = addr[OFFW-1:0];

  // Byte enables and lane-replicated store data are formed from the raw inputs and latched at accept.
  always_comb begin
    be_in      = '0;
    wdata_rep  = wdata;
    aligned_in = 1'b1;
    case (op_size(op))
      SZ_B: begin
        be_in     = NB'(1) << off_in;
        wdata_rep = {NB{wdata[7:0]}};
      end
      SZ_H: begin
        be_in      = NB'(3) << off_in;
        wdata_rep  = {(NB/2){wdata[15:0]}};
        aligned_in = ~off_in[0];
      end
      SZ_W: begin
        be_in      = '1;
        aligned_in = (off_in == '0);
      end
      default: ;
    endcase
  end

  load_align #(
    .BUS_WIDTH(BUS_WIDTH),
    .OFFW     (OFFW)
  ) u_load_align (
    .mem_rdata(mem_rdata),
    .offset   (off_q),
    .op       (op_q),
    .rdata    (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= MEM_NONE;
      off_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && op != MEM_NONE) begin
            busy  <= 1'b1;
            op_q  <= op;
            off_q <= off_in;
            if (aligned_in) begin
              state     <= ACCESS;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= op_is_store(op);
              mem_addr  <= {addr[BUS_WIDTH-1:OFFW], {OFFW{1'b0}}};
              mem_be    <= be_in;
              mem_wdata <= wdata_rep;
            end else begin
              state      <= ERR;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // An ack in the final timeout cycle still completes normally.
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            if (!op_is_store(op_q)) rdata <= load_data;
          end else if (cnt == CNTW'(TIMEOUT - 1)) begin
            state   <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP, ERR: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          misaligned <= 1'b0;
          bus_err    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  mem_op       op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  load_store_unit #(.BUS_WIDTH(32), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .misaligned(misaligned),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns in the cycle after the accepting edge.
  task automatic issue(input mem_op o, input logic [31:0] a, input logic [31:0] w);
    op    = o;
    addr  = a;
    wdata = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = MEM_NONE;
    addr  = 32'hFFFF_FFFF;
    wdata = 32'h0;
  endtask

  // Ack for one cycle; returns in the following (done) cycle.
  task automatic ack_with(input logic [31:0] rd);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'hA5A5_A5A5;
  endtask

  initial begin
    int req_cycles;
    rst       = 1'b1;
    start     = 1'b0;
    op        = MEM_NONE;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_rdata = 32'hA5A5_A5A5;
    mem_ack   = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    tick();

    // start with MEM_NONE is ignored
    issue(MEM_NONE, 32'h100, 32'h0);
    chk("none_busy", busy, 0);
    chk("none_req", mem_req, 0);

    // 1: SW, ack in first request cycle, done at N+2
    issue(SW, 32'h100, 32'hDEAD_BEEF);
    chk("sw_req", mem_req, 1);
    chk("sw_we", mem_we, 1);
    chk("sw_addr", mem_addr, 32'h100);
    chk("sw_be", mem_be, 4'b1111);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_busy", busy, 1);
    chk("sw_done_early", done, 0);
    ack_with(32'h0);
    chk("sw_done", done, 1);
    chk("sw_req_drop", mem_req, 0);
    chk("sw_busy_done", busy, 1);
    chk("sw_err", bus_err, 0);
    chk("sw_rdata", rdata, 0);
    tick();
    chk("sw_idle_busy", busy, 0);
    chk("sw_idle_done", done, 0);

    // 2: LB / LBU at byte offset 3
    issue(LB, 32'h103, 32'h0);
    chk("lb_be", mem_be, 4'b1000);
    chk("lb_addr", mem_addr, 32'h100);
    chk("lb_we", mem_we, 0);
    ack_with(32'h80FF_0000);
    chk("lb_done", done, 1);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    tick();
    issue(LBU, 32'h103, 32'h0);
    ack_with(32'h80FF_0000);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    tick();

    // 3: LH / LHU / SH at half offset 2
    issue(LH, 32'h102, 32'h0);
    ack_with(32'h8001_1234);
    chk("lh_rdata", rdata, 32'hFFFF_8001);
    tick();
    issue(LHU, 32'h102, 32'h0);
    ack_with(32'h8001_1234);
    chk("lhu_rdata", rdata, 32'h0000_8001);
    tick();
    issue(SH, 32'h102, 32'h0000_ABCD);
    chk("sh_be", mem_be, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    chk("sh_we", mem_we, 1);
    ack_with(32'h1111_2222);
    chk("sh_rdata_kept", rdata, 32'h0000_8001);
    tick();

    // 4: misaligned LW
    issue(LW, 32'h101, 32'h0);
    chk("mis_done", done, 1);
    chk("mis_flag", misaligned, 1);
    chk("mis_req", mem_req, 0);
    chk("mis_busy", busy, 1);
    chk("mis_err", bus_err, 0);
    tick();
    chk("mis_busy_end", busy, 0);
    chk("mis_done_end", done, 0);
    chk("mis_flag_end", misaligned, 0);
    chk("mis_req_end", mem_req, 0);

    // 5a: no ack -> mem_req for exactly 16 cycles then bus_err
    issue(LW, 32'h200, 32'h0);
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      req_cycles++;
      tick();
    end
    chk("to_req_cycles", req_cycles, 16);
    chk("to_done", done, 1);
    chk("to_err", bus_err, 1);
    chk("to_mis", misaligned, 0);
    tick();
    chk("to_err_clear", bus_err, 0);

    // 5b: ack in the 16th cycle wins; a start pulse while busy is dropped
    issue(LW, 32'h200, 32'h0);
    op    = LB;
    addr  = 32'h111;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = MEM_NONE;
    for (int i = 0; i < 14; i++) tick();
    chk("late_req", mem_req, 1);
    chk("late_addr", mem_addr, 32'h200);
    ack_with(32'h1234_5678);
    chk("late_done", done, 1);
    chk("late_err", bus_err, 0);
    chk("late_rdata", rdata, 32'h1234_5678);
    tick();
    tick();
    chk("noqueue_busy", busy, 0);
    chk("noqueue_req", mem_req, 0);

    // 6: reset mid-ACCESS, then a late ack
    issue(LW, 32'h300, 32'h0);
    op    = SW;
    addr  = 32'h400;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = MEM_NONE;
    chk("busy_ign_addr", mem_addr, 32'h300);
    chk("busy_ign_we", mem_we, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_req", mem_req, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_rdata", rdata, 0);
    ack_with(32'hCAFE_F00D);
    chk("lateack_done", done, 0);
    chk("lateack_busy", busy, 0);
    chk("lateack_rdata", rdata, 0);
    tick();
    chk("lateack_done2", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
